// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op encoding, default latencies and the
// arithmetic kernels. Kernels work on MdMaxWidth-bit operands; narrower units extend first.
package md_pkg;

    typedef enum logic [2:0] {
        OpMult  = 3'b000,
        OpMultu = 3'b001,
        OpDiv   = 3'b010,
        OpDivu  = 3'b011,
        OpMadd  = 3'b100,
        OpMsub  = 3'b101,
        OpMthi  = 3'b110,
        OpMtlo  = 3'b111
    } md_op_e;

    localparam int unsigned MdMaxWidth      = 32;
    localparam int unsigned MdMulLatDefault = 5;
    localparam int unsigned MdDivLatDefault = 10;

    typedef struct packed {
        logic [MdMaxWidth-1:0] quo;
        logic [MdMaxWidth-1:0] rem;
    } md_div_t;

    // Full-width product; with sgn set the operands are treated as two's complement.
    function automatic logic [2*MdMaxWidth-1:0] md_mul(input logic [MdMaxWidth-1:0] a,
                                                       input logic [MdMaxWidth-1:0] b,
                                                       input logic              sgn);
        logic [2*MdMaxWidth-1:0] ea;
        logic [2*MdMaxWidth-1:0] eb;
        ea = {{MdMaxWidth{sgn & a[MdMaxWidth-1]}}, a};
        eb = {{MdMaxWidth{sgn & b[MdMaxWidth-1]}}, b};
        return ea * eb;
    endfunction

    // Quotient truncates toward zero, remainder takes the dividend's sign.
    function automatic md_div_t md_div(input logic [MdMaxWidth-1:0] a,
                                       input logic [MdMaxWidth-1:0] b,
                                       input logic              sgn);
        md_div_t               res;
        logic [MdMaxWidth-1:0] min_neg;
        min_neg = {1'b1, {(MdMaxWidth-1){1'b0}}};
        if (b == '0) begin
            res.quo = '1;
            res.rem = a;
        end else if (sgn && a == min_neg && b == '1) begin
            res.quo = a;
            res.rem = '0;
        end else if (sgn) begin
            res.quo = MdMaxWidth'($signed(a) / $signed(b));
            res.rem = MdMaxWidth'($signed(a) % $signed(b));
        end else begin
            res.quo = a / b;
            res.rem = a % b;
        end
        return res;
    endfunction

endpackage

// File: rtl/md_unit_if.sv
// Issue/result bundle between the EX stage and the multiply/divide unit.
interface md_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start_i;
    logic [2:0]       op_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             flush_i;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;

    modport master (
        output start_i, op_i, a_i, b_i, flush_i,
        input  busy_o, done_o, hi_o, lo_o
    );

    modport slave (
        input  start_i, op_i, a_i, b_i, flush_i,
        output busy_o, done_o, hi_o, lo_o
    );
endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers. WIDTH may not exceed MdMaxWidth;
// MUL_LAT and DIV_LAT must be at least 1.
module md_unit
    import md_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned MUL_LAT = MdMulLatDefault,
    parameter int unsigned DIV_LAT = MdDivLatDefault
) (
    input logic      clk,
    input logic      reset_n,
    md_unit_if.slave md
);

    localparam int unsigned MaxLat = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int unsigned CntW   = $clog2(MaxLat + 1);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e           state_q;
    logic [CntW-1:0]  cnt_q;
    md_op_e           op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             busy_q;
    logic             done_q;

    md_op_e                  op_in;
    logic                    sgn;
    logic [MdMaxWidth-1:0]   a_ext;
    logic [MdMaxWidth-1:0]   b_ext;
    logic [2*MdMaxWidth-1:0] prod_full;
    md_div_t                 div_res;
    logic [2*WIDTH-1:0]      prod;
    logic [2*WIDTH-1:0]      hilo;
    logic [2*WIDTH-1:0]      result;

    assign op_in = md_op_e'(md.op_i);

    always_comb begin
        sgn       = (op_q inside {OpMult, OpMadd, OpMsub, OpDiv});
        a_ext     = sgn ? MdMaxWidth'($signed(a_q)) : MdMaxWidth'(a_q);
        b_ext     = sgn ? MdMaxWidth'($signed(b_q)) : MdMaxWidth'(b_q);
        prod_full = md_mul(a_ext, b_ext, sgn);
        div_res   = md_div(a_ext, b_ext, sgn);
        prod      = prod_full[2*WIDTH-1:0];
        hilo      = {hi_q, lo_q};
        // MADD/MSUB accumulate onto HI/LO as they stand at commit time.
        unique case (op_q)
            OpMult, OpMultu: result = prod;
            OpMadd:          result = hilo + prod;
            OpMsub:          result = hilo - prod;
            OpDiv, OpDivu:   result = {div_res.rem[WIDTH-1:0], div_res.quo[WIDTH-1:0]};
            default:         result = hilo;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            op_q    <= OpMult;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (md.start_i && !md.flush_i) begin
                        if (op_in == OpMthi) begin
                            hi_q <= md.a_i;
                        end else if (op_in == OpMtlo) begin
                            lo_q <= md.a_i;
                        end else begin
                            op_q    <= op_in;
                            a_q     <= md.a_i;
                            b_q     <= md.b_i;
                            cnt_q   <= (op_in inside {OpDiv, OpDivu}) ? CntW'(DIV_LAT)
                                                                     : CntW'(MUL_LAT);
                            state_q <= StRun;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    if (md.flush_i) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else if (cnt_q == CntW'(1)) begin
                        {hi_q, lo_q} <= result;
                        done_q       <= 1'b1;
                        state_q      <= StIdle;
                        busy_q       <= 1'b0;
                        cnt_q        <= '0;
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign md.busy_o = busy_q;
    assign md.done_o = done_q;
    assign md.hi_o   = hi_q;
    assign md.lo_o   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: drives and samples on the falling edge, checks against
// hand-computed constants.
module tb_md_unit;

    localparam logic [2:0] MULT  = 3'b000;
    localparam logic [2:0] MULTU = 3'b001;
    localparam logic [2:0] DIV   = 3'b010;
    localparam logic [2:0] DIVU  = 3'b011;
    localparam logic [2:0] MADD  = 3'b100;
    localparam logic [2:0] MSUB  = 3'b101;
    localparam logic [2:0] MTHI  = 3'b110;
    localparam logic [2:0] MTLO  = 3'b111;

    logic clk;
    logic reset_n;
    int   vectors;
    int   miscompares;
    int   n;
    bit   early_done;

    md_unit_if #(.WIDTH(32)) mif ();

    md_unit #(
        .WIDTH  (32),
        .MUL_LAT(5),
        .DIV_LAT(10)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .md     (mif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        mif.start_i = 1'b1;
        mif.op_i    = op;
        mif.a_i     = a;
        mif.b_i     = b;
        @(negedge clk);
        mif.start_i = 1'b0;
    endtask

    // Counts falling edges with busy high; bounded so a stuck unit still reaches the summary.
    task automatic wait_idle(output int cycles, output bit saw_done);
        cycles   = 0;
        saw_done = 1'b0;
        while (mif.busy_o === 1'b1 && cycles < 100) begin
            if (mif.done_o === 1'b1) saw_done = 1'b1;
            cycles++;
            @(negedge clk);
        end
    endtask

    task automatic run(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int lat, input logic [63:0] exp);
        issue(op, a, b);
        wait_idle(n, early_done);
        chk({tag, "_lat"}, 64'(n), 64'(lat));
        chk({tag, "_early_done"}, 64'(early_done), 64'd0);
        chk({tag, "_done"}, 64'(mif.done_o), 64'd1);
        chk({tag, "_hilo"}, {mif.hi_o, mif.lo_o}, exp);
        @(negedge clk);
        chk({tag, "_done_clr"}, 64'(mif.done_o), 64'd0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b0;
        mif.start_i = 1'b0;
        mif.op_i    = MULT;
        mif.a_i     = '0;
        mif.b_i     = '0;
        mif.flush_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(mif.busy_o), 64'd0);
        chk("rst_done", 64'(mif.done_o), 64'd0);
        chk("rst_hilo", {mif.hi_o, mif.lo_o}, 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        run("mult", MULT, 32'hFFFF_FFFD, 32'd7, 5, 64'hFFFF_FFFF_FFFF_FFEB);
        run("multu", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 64'hFFFF_FFFE_0000_0001);
        run("divu", DIVU, 32'd100, 32'd7, 10, {32'd2, 32'd14});
        run("div_neg", DIV, 32'hFFFF_FFF9, 32'd2, 10, 64'hFFFF_FFFF_FFFF_FFFD);
        run("div_zero", DIV, 32'd5, 32'd0, 10, {32'd5, 32'hFFFF_FFFF});
        run("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, {32'd0, 32'h8000_0000});

        issue(MTHI, 32'h1234_5678, 32'd0);
        chk("mthi_busy", 64'(mif.busy_o), 64'd0);
        chk("mthi_hi", 64'(mif.hi_o), 64'h1234_5678);
        issue(MTLO, 32'hFFFF_FFFF, 32'd0);
        chk("mtlo_done", 64'(mif.done_o), 64'd0);
        chk("mtlo_lo", 64'(mif.lo_o), 64'hFFFF_FFFF);
        run("madd", MADD, 32'd2, 32'd3, 5, 64'h1234_5679_0000_0005);
        run("msub", MSUB, 32'hFFFF_FFFC, 32'd5, 5, 64'h1234_5679_0000_0019);

        // Flush on the third edge of a MULT.
        issue(MULT, 32'd2, 32'd2);
        repeat (2) @(negedge clk);
        mif.flush_i = 1'b1;
        @(negedge clk);
        mif.flush_i = 1'b0;
        chk("flush_busy", 64'(mif.busy_o), 64'd0);
        chk("flush_done", 64'(mif.done_o), 64'd0);
        repeat (6) begin
            @(negedge clk);
            chk("flush_no_done", 64'(mif.done_o), 64'd0);
        end
        chk("flush_hilo", {mif.hi_o, mif.lo_o}, 64'h1234_5679_0000_0019);

        // Flush in IDLE suppresses both single-cycle and multi-cycle starts.
        mif.flush_i = 1'b1;
        issue(MTHI, 32'hAAAA_AAAA, 32'd0);
        chk("idle_flush_mthi", 64'(mif.hi_o), 64'h1234_5679);
        issue(MULT, 32'd4, 32'd4);
        chk("idle_flush_busy", 64'(mif.busy_o), 64'd0);
        mif.flush_i = 1'b0;

        // A start while busy is ignored.
        issue(MULT, 32'd3, 32'd3);
        @(negedge clk);
        issue(MTHI, 32'hDEAD_BEEF, 32'd0);
        wait_idle(n, early_done);
        chk("busy_start_lat", 64'(n), 64'd3);
        chk("busy_start_hilo", {mif.hi_o, mif.lo_o}, 64'd9);
        @(negedge clk);

        // Asynchronous reset in the middle of a DIVU.
        issue(DIVU, 32'd100, 32'd7);
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("areset_busy", 64'(mif.busy_o), 64'd0);
        chk("areset_hilo", {mif.hi_o, mif.lo_o}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run("post_rst", MULT, 32'd6, 32'd7, 5, 64'd42);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
